// File: rtl/wbp2classic_fifo.sv
// rtl/wbp2classic_fifo.sv - pipelined-to-classic Wishbone bridge with a request FIFO
// Requests queue in a small FIFO and are replayed as classic cycles, bursting when addresses run sequentially.
module wbp2classic_fifo #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int LGFIFO    = 2,
  parameter bit OPT_BURST = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_mcyc,
  input  logic            i_mstb,
  input  logic            i_mwe,
  input  logic [AW-1:0]   i_maddr,
  input  logic [DW-1:0]   i_mdata,
  input  logic [DW/8-1:0] i_msel,
  output logic            o_mstall,
  output logic            o_mack,
  output logic            o_merr,
  output logic [DW-1:0]   o_mdata,
  output logic            o_scyc,
  output logic            o_sstb,
  output logic            o_swe,
  output logic [AW-1:0]   o_saddr,
  output logic [DW-1:0]   o_sdata,
  output logic [DW/8-1:0] o_ssel,
  input  logic            i_sack,
  input  logic            i_serr,
  input  logic [DW-1:0]   i_sdata,
  output logic [2:0]      o_scti,
  output logic [1:0]      o_sbti
);
  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0]   FULL_CNT = (LGFIFO+1)'(DEPTH);
  localparam logic [LGFIFO:0]   TWO_CNT  = (LGFIFO+1)'(2);
  localparam logic [LGFIFO-1:0] PTR_ONE  = LGFIFO'(1);
  localparam logic [AW-1:0]     ADDR_ONE = AW'(1);
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP, S_ERR} state_t;
  state_t state;

  logic            we_mem   [DEPTH];
  logic [AW-1:0]   addr_mem [DEPTH];
  logic [DW-1:0]   data_mem [DEPTH];
  logic [DW/8-1:0] sel_mem  [DEPTH];

  logic [LGFIFO-1:0] wr_ptr, rd_ptr;
  logic [LGFIFO:0]   count;
  logic fifo_full, fifo_empty;
  logic push, pop, fail, flush, enter_xfer;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign o_mstall   = fifo_full || (state == S_ERR);
  assign push       = i_mcyc && i_mstb && !o_mstall;
  assign pop        = i_mcyc && (state == S_XFER) && i_sack && !i_serr;
  assign fail       = i_mcyc && (state == S_XFER) && i_serr;
  assign flush      = !i_mcyc || fail;

  // The burst decision looks at the FIFO as it will be after this edge,
  // including an entry being pushed right now.
  logic [LGFIFO-1:0] nx_head, nx_second;
  logic [LGFIFO:0]   nx_count;
  logic              nx_we0, nx_we1;
  logic [AW-1:0]     nx_addr0, nx_addr1;
  logic              burst_ok;
  logic [2:0]        cti_next;

  assign nx_head   = rd_ptr + LGFIFO'(pop);
  assign nx_second = nx_head + PTR_ONE;
  assign nx_count  = count + (LGFIFO+1)'(push) - (LGFIFO+1)'(pop);
  assign nx_we0    = (push && wr_ptr == nx_head)   ? i_mwe   : we_mem[nx_head];
  assign nx_addr0  = (push && wr_ptr == nx_head)   ? i_maddr : addr_mem[nx_head];
  assign nx_we1    = (push && wr_ptr == nx_second) ? i_mwe   : we_mem[nx_second];
  assign nx_addr1  = (push && wr_ptr == nx_second) ? i_maddr : addr_mem[nx_second];

  assign burst_ok = (nx_count >= TWO_CNT) && (nx_addr0 != '1)
                    && (nx_addr1 == nx_addr0 + ADDR_ONE) && (nx_we1 == nx_we0);
  assign cti_next = !OPT_BURST ? CTI_CLASSIC : (burst_ok ? CTI_INCR : CTI_END);

  always_comb begin
    enter_xfer = 1'b0;
    if (i_mcyc) begin
      case (state)
        S_IDLE, S_GAP: enter_xfer = !fifo_empty;
        S_XFER:        enter_xfer = pop && (o_scti == CTI_INCR);
        default:       enter_xfer = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      we_mem[wr_ptr]   <= i_mwe;
      addr_mem[wr_ptr] <= i_maddr;
      data_mem[wr_ptr] <= i_mdata;
      sel_mem[wr_ptr]  <= i_msel;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_mack  <= 1'b0;
      o_merr  <= 1'b0;
      o_mdata <= '0;
      o_scti  <= '0;
    end else begin
      o_mack <= pop;
      o_merr <= fail;
      if (pop)
        o_mdata <= i_sdata;
      if (enter_xfer)
        o_scti <= cti_next;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
        count <= nx_count;
      end

      if (!i_mcyc) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (!fifo_empty) state <= S_XFER;
          S_XFER: begin
            if (fail)
              state <= S_ERR;
            else if (pop)
              state <= (o_scti == CTI_INCR) ? S_XFER : S_GAP;
          end
          S_GAP:  state <= fifo_empty ? S_IDLE : S_XFER;
          S_ERR:  state <= S_ERR;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Dropping i_mcyc kills the slave cycle in the same clock.
  assign o_sstb  = i_mcyc && (state == S_XFER);
  assign o_scyc  = i_mcyc && ((state == S_XFER) || ((state == S_GAP) && !fifo_empty));
  assign o_swe   = we_mem[rd_ptr];
  assign o_saddr = addr_mem[rd_ptr];
  assign o_sdata = data_mem[rd_ptr];
  assign o_ssel  = sel_mem[rd_ptr];
  assign o_sbti  = 2'b00;

endmodule

// File: tb/tb_wbp2classic_fifo.sv
// tb/tb_wbp2classic_fifo.sv - self-checking bench for wbp2classic_fifo
// A transaction queue model predicts stall, slave fields, cycle types and master responses.
module tb_wbp2classic_fifo;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LGFIFO = 2;
  localparam int DEPTH = 4;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_mcyc, i_mstb, i_mwe;
  logic [AW-1:0]   i_maddr;
  logic [DW-1:0]   i_mdata;
  logic [DW/8-1:0] i_msel;
  logic            o_mstall, o_mack, o_merr;
  logic [DW-1:0]   o_mdata;
  logic            o_scyc, o_sstb, o_swe;
  logic [AW-1:0]   o_saddr;
  logic [DW-1:0]   o_sdata;
  logic [DW/8-1:0] o_ssel;
  logic            i_sack, i_serr;
  logic [DW-1:0]   i_sdata;
  logic [2:0]      o_scti;
  logic [1:0]      o_sbti;

  wbp2classic_fifo #(.AW(AW), .DW(DW), .LGFIFO(LGFIFO), .OPT_BURST(1'b1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
    .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
    .o_mstall(o_mstall), .o_mack(o_mack), .o_merr(o_merr), .o_mdata(o_mdata),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata),
    .o_scti(o_scti), .o_sbti(o_sbti)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] sel;
  } req_t;

  req_t q[$];
  int tests = 0;
  int fails = 0;

  logic m_cyc, m_stb, m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data, s_data;
  logic [DW/8-1:0] m_sel;
  bit rand_slave, err_mode, force_ack;
  int ack_wait;

  bit in_err, exp_mack, exp_merr;
  logic [DW-1:0] exp_mdata;
  bit prev_sstb, prev_done;
  logic [2:0] prev_cti, cur_cti;
  int xfer_len;
  logic [2:0] cti_log[$];
  int n_mack, n_merr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_cti();
    logic [AW-1:0] a0;
    if (q.size() < 2) return 3'b111;
    a0 = q[0].addr;
    if (a0 != {AW{1'b1}} && q[1].addr == a0 + AW'(1) && q[1].we == q[0].we) return 3'b010;
    return 3'b111;
  endfunction

  task automatic step();
    bit exp_stall, accept, ack_ev, err_ev, new_xfer, sstb_s;
    logic [2:0] cti_s;
    req_t r;
    i_mcyc = m_cyc; i_mstb = m_stb; i_mwe = m_we; i_maddr = m_addr;
    i_mdata = m_data; i_msel = m_sel; i_sdata = s_data;
    i_sack = 1'b0; i_serr = 1'b0;
    #1;
    new_xfer = o_sstb && (!prev_sstb || prev_done);
    if (new_xfer) xfer_len = 0;
    if (rand_slave) begin
      i_sack = ($urandom_range(0, 2) == 0);
      i_serr = ($urandom_range(0, 40) == 0);
    end else if (o_sstb && xfer_len >= ack_wait) begin
      if (err_mode) i_serr = 1'b1;
      else i_sack = 1'b1;
    end
    if (force_ack) i_sack = 1'b1;
    #1;
    exp_stall = (q.size() == DEPTH) || in_err;
    chk("mstall", o_mstall, exp_stall);
    chk("mack", o_mack, exp_mack);
    chk("merr", o_merr, exp_merr);
    if (exp_mack) chk("mdata", o_mdata, exp_mdata);
    if (o_mack) n_mack++;
    if (o_merr) n_merr++;
    if (!i_mcyc || in_err) begin
      chk("scyc_off", o_scyc, 0);
      chk("sstb_off", o_sstb, 0);
    end
    if (i_mcyc && prev_done) chk("burst_follow", o_sstb, prev_cti == 3'b010);
    if (i_mcyc && prev_done && prev_cti != 3'b010) chk("gap_scyc", o_scyc, q.size() != 0);
    if (o_sstb) begin
      chk("sstb_nonempty", q.size() != 0, 1);
      chk("scyc_with_stb", o_scyc, 1);
      if (q.size() != 0) begin
        chk("swe", o_swe, q[0].we);
        chk("saddr", o_saddr, q[0].addr);
        chk("sdata", o_sdata, q[0].data);
        chk("ssel", o_ssel, q[0].sel);
      end
      if (new_xfer) cur_cti = exp_cti();
      chk("scti", o_scti, cur_cti);
    end
    chk("sbti", o_sbti, 0);
    sstb_s = o_sstb;
    cti_s  = o_scti;
    accept = i_mcyc && i_mstb && !exp_stall;
    ack_ev = sstb_s && i_mcyc && i_sack && !i_serr;
    err_ev = sstb_s && i_mcyc && i_serr;
    r = '{i_mwe, i_maddr, i_mdata, i_msel};
    if (ack_ev) cti_log.push_back(cti_s);
    @(posedge i_clk);
    exp_mack = 1'b0;
    exp_merr = 1'b0;
    if (!i_mcyc) begin
      q.delete();
      in_err = 1'b0;
    end else if (err_ev) begin
      q.delete();
      in_err = 1'b1;
      exp_merr = 1'b1;
    end else begin
      if (ack_ev) begin
        void'(q.pop_front());
        exp_mack = 1'b1;
        exp_mdata = i_sdata;
      end
      if (accept) q.push_back(r);
    end
    if (sstb_s) xfer_len++;
    prev_sstb = sstb_s && i_mcyc;
    prev_done = ack_ev;
    prev_cti  = cti_s;
    @(negedge i_clk);
  endtask

  task automatic push1(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_addr = addr; m_data = data; m_sel = 4'hF;
    step();
    m_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_pulse();
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("rst_mack", o_mack, 0);
    chk("rst_merr", o_merr, 0);
    chk("rst_mdata", o_mdata, 0);
    chk("rst_scyc", o_scyc, 0);
    chk("rst_sstb", o_sstb, 0);
    chk("rst_scti", o_scti, 0);
    chk("rst_mstall", o_mstall, 0);
    q.delete();
    in_err = 1'b0; exp_mack = 1'b0; exp_merr = 1'b0;
    prev_sstb = 1'b0; prev_done = 1'b0; xfer_len = 0;
    @(negedge i_clk);
    #2;
    i_reset_n = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    int n0, e0;
    m_cyc = 0; m_stb = 0; m_we = 0; m_addr = '0; m_data = '0; m_sel = '0; s_data = '0;
    rand_slave = 0; err_mode = 0; force_ack = 0; ack_wait = 0;
    in_err = 0; exp_mack = 0; exp_merr = 0; exp_mdata = '0;
    prev_sstb = 0; prev_done = 0; prev_cti = '0; cur_cti = '0; xfer_len = 0;
    n_mack = 0; n_merr = 0;
    i_mcyc = 0; i_mstb = 0; i_mwe = 0; i_maddr = '0; i_mdata = '0; i_msel = '0;
    i_sack = 0; i_serr = 0; i_sdata = '0;
    i_reset_n = 1'b0;
    @(negedge i_clk);
    #1;
    chk("init_mack", o_mack, 0);
    chk("init_scyc", o_scyc, 0);
    chk("init_scti", o_scti, 0);
    chk("init_mstall", o_mstall, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // single read acked on the second strobe cycle
    ack_wait = 1; s_data = 32'hDEADBEEF; cti_log.delete(); n0 = n_mack;
    push1(1'b0, 12'h010, 32'h0);
    idle(6);
    chk("r037_nack", cti_log.size(), 1);
    chk("r037_cti", cti_log[0], 3'b111);
    chk("r037_macks", n_mack - n0, 1);

    // four sequential writes held until the FIFO is full, then drained
    ack_wait = 1000; cti_log.delete(); n0 = n_mack;
    for (int i = 0; i < 4; i++) push1(1'b1, AW'(12'h100 + i), $urandom);
    idle(1);
    chk("r038_full_stall", o_mstall, 1);
    ack_wait = 0; s_data = 32'h12345678;
    idle(8);
    chk("r038_nack", cti_log.size(), 4);
    for (int i = 0; i < 3; i++) chk("r038_cti_burst", cti_log[i], 3'b010);
    chk("r038_cti_last", cti_log[3], 3'b111);
    chk("r038_macks", n_mack - n0, 4);

    // address wrap breaks a burst
    ack_wait = 1000; cti_log.delete();
    push1(1'b1, 12'hFFF, 32'hA5A5A5A5);
    push1(1'b1, 12'h000, 32'h5A5A5A5A);
    idle(1);
    ack_wait = 0;
    idle(8);
    chk("r039_nack", cti_log.size(), 2);
    chk("r039_cti0", cti_log[0], 3'b111);
    chk("r039_cti1", cti_log[1], 3'b111);

    // error on the first of three queued reads
    ack_wait = 1000; n0 = n_mack; e0 = n_merr;
    for (int i = 0; i < 3; i++) push1(1'b0, AW'(12'h200 + i), 32'h0);
    err_mode = 1; ack_wait = 0;
    idle(5);
    chk("r040_merrs", n_merr - e0, 1);
    chk("r040_macks", n_mack - n0, 0);
    chk("r040_stall", o_mstall, 1);
    err_mode = 0; m_cyc = 0;
    step();
    m_cyc = 1;
    idle(3);
    chk("r040_nostb", o_sstb, 0);

    // cycle dropped together with the slave ack
    ack_wait = 1000; n0 = n_mack;
    push1(1'b1, 12'h300, 32'h1);
    push1(1'b1, 12'h301, 32'h2);
    idle(1);
    m_cyc = 0; force_ack = 1;
    step();
    force_ack = 0; m_cyc = 1;
    idle(3);
    chk("r041_macks", n_mack - n0, 0);
    chk("r041_nostb", o_sstb, 0);

    // reset in the middle of a burst, then a normal write
    ack_wait = 1000;
    for (int i = 0; i < 4; i++) push1(1'b1, AW'(12'h400 + i), $urandom);
    ack_wait = 0;
    step();
    reset_pulse();
    cti_log.delete(); n0 = n_mack;
    push1(1'b1, 12'h020, 32'hCAFEF00D);
    idle(5);
    chk("r042_nack", cti_log.size(), 1);
    chk("r042_cti", cti_log[0], 3'b111);
    chk("r042_macks", n_mack - n0, 1);

    // randomized traffic with a random slave
    rand_slave = 1;
    for (int i = 0; i < 600; i++) begin
      m_cyc = ($urandom_range(0, 20) != 0);
      m_stb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        m_addr = ($urandom_range(0, 5) == 0) ? 12'hFFE : AW'($urandom);
      else
        m_addr = m_addr + AW'(1);
      if ($urandom_range(0, 5) == 0) m_we = ~m_we;
      m_data = $urandom; m_sel = 4'($urandom); s_data = $urandom;
      step();
      if (i == 300) reset_pulse();
    end

    // drain whatever remains queued
    rand_slave = 0; ack_wait = 0; m_stb = 0; m_cyc = 1;
    if (in_err) begin
      m_cyc = 0;
      step();
      m_cyc = 1;
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    chk("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
